// File: rtl/shift_pipe_param_pkg.sv
// Shared helpers for the parametrised shift pipeline.
// Holds default sizing and the tap-select clamp.
package shift_pipe_param_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;

    // Never narrower than one bit, even for a single-stage pipe.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int clamp_sel(input int sel, input int depth);
        return (sel > depth) ? depth : sel;
    endfunction

endpackage

// File: rtl/shift_pipe_param_stage.sv
// One pipeline stage: WIDTH-bit data register plus a valid bit.
// Flush clears only the valid bit; data is left in place.
module shift_pipe_stage
    import shift_pipe_param_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             vld_d;
    logic             vld_q;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (en) begin
            data_d = d;
            vld_d  = d_vld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q     = data_q;
    assign q_vld = vld_q;

endmodule

// File: rtl/shift_pipe_param.sv
// Parametrised delay line with stall, flush, selectable tap
// (including zero-delay bypass), per-stage taps and occupancy.
module shift_pipe_param
    import shift_pipe_param_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SELW  = clog2_min1(DEPTH + 1),
    parameter int CNTW  = clog2_min1(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic [SELW-1:0]        sel,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_vld,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_vld,
    output logic [WIDTH*DEPTH-1:0] taps,
    output logic [CNTW-1:0]        occ
);

    logic [WIDTH-1:0] s [DEPTH];
    logic             v [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;

        if (k == 0) begin : g_head
            assign d_in = din;
            assign v_in = din_vld;
        end else begin : g_body
            assign d_in = s[k-1];
            assign v_in = v[k-1];
        end

        shift_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .clr   (clr),
            .d     (d_in),
            .d_vld (v_in),
            .q     (s[k]),
            .q_vld (v[k])
        );

        assign taps[k*WIDTH +: WIDTH] = s[k];
    end

    int sel_c;

    always_comb begin
        sel_c    = clamp_sel(int'(sel), DEPTH);
        dout     = din;
        dout_vld = din_vld;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel_c == k + 1) begin
                dout     = s[k];
                dout_vld = v[k];
            end
        end
    end

    // Count the valid bits the stages will hold after this edge.
    logic [CNTW-1:0] occ_d;
    logic [CNTW-1:0] occ_q;
    int              cnt;

    always_comb begin
        cnt   = 0;
        occ_d = occ_q;
        if (clr) begin
            occ_d = '0;
        end else if (en) begin
            cnt = din_vld ? 1 : 0;
            for (int k = 0; k < DEPTH - 1; k++) begin
                cnt = cnt + (v[k] ? 1 : 0);
            end
            occ_d = CNTW'(cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;

endmodule

// File: tb/tb_shift_pipe_param.sv
// Self-checking bench for shift_pipe_param: directed scenarios on a
// 4x2 build plus a random run shared by 4x2, 16x8 and 1x1 builds.
module tb_shift_pipe_param;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic [1:0]  sel;
    logic [3:0]  din;
    logic        din_vld;
    logic [3:0]  dout;
    logic        dout_vld;
    logic [7:0]  taps;
    logic [1:0]  occ;

    logic [3:0]   sel8;
    logic [15:0]  din16;
    logic [15:0]  dout8;
    logic         dout8_vld;
    logic [127:0] taps8;
    logic [3:0]   occ8;

    logic [0:0] sel1;
    logic [0:0] dout1;
    logic       dout1_vld;
    logic [0:0] taps1;
    logic [0:0] occ1;

    int checks;
    int errors;

    logic [3:0]  sbv [$];
    int          sbt [$];
    logic [16:0] h [$];

    shift_pipe_param #(.WIDTH(4), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sel(sel),
        .din(din), .din_vld(din_vld), .dout(dout),
        .dout_vld(dout_vld), .taps(taps), .occ(occ)
    );

    shift_pipe_param #(.WIDTH(16), .DEPTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sel(sel8),
        .din(din16), .din_vld(din_vld), .dout(dout8),
        .dout_vld(dout8_vld), .taps(taps8), .occ(occ8)
    );

    shift_pipe_param #(.WIDTH(1), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sel(sel1),
        .din(din16[0:0]), .din_vld(din_vld), .dout(dout1),
        .dout_vld(dout1_vld), .taps(taps1), .occ(occ1)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_pipe();
        clr     = 1'b1;
        en      = 1'b1;
        din_vld = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 0; en = 0; clr = 0; sel = 2'd1;
        din = 0; din_vld = 0; sel8 = 0; sel1 = 0; din16 = 0;
        #5 rst = 1;
        #5;
        checks++;
        if (taps !== 8'h00) begin
            errors++;
            $display("FAIL reset_taps: got %h want 00", taps);
        end
        checks++;
        if (occ !== 2'd0) begin
            errors++;
            $display("FAIL reset_occ: got %0d want 0", occ);
        end
        checks++;
        if (dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld_sel1: got %b want 0", dout_vld);
        end
        checks++;
        if (taps8 !== 128'h0 || occ8 !== 4'd0) begin
            errors++;
            $display("FAIL reset_wide: taps %h occ %0d want 0", taps8, occ8);
        end
        sel = 2'd0; din = 4'h5; din_vld = 1'b1;
        #1;
        checks++;
        if (dout !== 4'h5 || dout_vld !== 1'b1) begin
            errors++;
            $display("FAIL reset_bypass: got %h/%b want 5/1", dout, dout_vld);
        end
        din_vld = 1'b0; din = 4'h0; sel = 2'd2;
        #10 rst = 0;
    endtask

    task automatic test_stream_taps();
        logic [3:0] vals [5];
        logic [1:0] eo;
        vals = '{4'h3, 4'h7, 4'hF, 4'hA, 4'h2};
        sel = 2'd2; en = 1'b1; clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = vals[i];
            din_vld = 1'b1;
            tick();
            eo = (i == 0) ? 2'd1 : 2'd2;
            checks++;
            if (taps[3:0] !== vals[i]) begin
                errors++;
                $display("FAIL taps_s0[%0d]: got %h want %h", i, taps[3:0], vals[i]);
            end
            if (i > 0) begin
                checks++;
                if (taps[7:4] !== vals[i-1] || dout !== vals[i-1] || dout_vld !== 1'b1) begin
                    errors++;
                    $display("FAIL taps_s1[%0d]: s1 %h dout %h/%b want %h/1",
                             i, taps[7:4], dout, dout_vld, vals[i-1]);
                end
            end
            checks++;
            if (occ !== eo) begin
                errors++;
                $display("FAIL taps_occ[%0d]: got %0d want %0d", i, occ, eo);
            end
        end
        din_vld = 1'b0;
    endtask

    task automatic run_stream(input logic [1:0] sel_v);
        logic [3:0] vals [5];
        logic [3:0] ev;
        int lat;
        int et;
        int c;
        vals = '{4'h3, 4'h7, 4'hF, 4'hA, 4'h2};
        flush_pipe();
        sel = sel_v;
        lat = (int'(sel_v) > 2) ? 2 : int'(sel_v);
        sbv.delete();
        sbt.delete();
        for (c = 0; c < 8; c++) begin
            if (c < 5) begin
                din = vals[c];
                din_vld = 1'b1;
                sbv.push_back(vals[c]);
                sbt.push_back(c + lat);
            end else begin
                din = 4'h0;
                din_vld = 1'b0;
            end
            #1;
            if (dout_vld === 1'b1) begin
                checks++;
                if (sbv.size() == 0) begin
                    errors++;
                    $display("FAIL stream_sel%0d: unexpected valid %h at %0d", sel_v, dout, c);
                end else begin
                    ev = sbv.pop_front();
                    et = sbt.pop_front();
                    if (dout !== ev || c != et) begin
                        errors++;
                        $display("FAIL stream_sel%0d: got %h at %0d want %h at %0d",
                                 sel_v, dout, c, ev, et);
                    end
                end
            end
            tick();
        end
        checks++;
        if (sbv.size() != 0) begin
            errors++;
            $display("FAIL stream_sel%0d_drain: %0d outputs missing want 0", sel_v, sbv.size());
        end
    endtask

    task automatic test_stall();
        flush_pipe();
        sel = 2'd2;
        din = 4'h3; din_vld = 1'b1; en = 1'b1;
        tick();
        checks++;
        if (taps[3:0] !== 4'h3 || occ !== 2'd1) begin
            errors++;
            $display("FAIL stall_e1: s0 %h occ %0d want 3/1", taps[3:0], occ);
        end
        din = 4'h7; en = 1'b0;
        tick();
        checks++;
        if (taps[3:0] !== 4'h3 || occ !== 2'd1 || dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: s0 %h occ %0d vld %b want 3/1/0",
                     taps[3:0], occ, dout_vld);
        end
        en = 1'b1;
        tick();
        checks++;
        if (taps !== 8'h37 || occ !== 2'd2 || dout !== 4'h3 || dout_vld !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: taps %h occ %0d dout %h/%b want 37/2/3/1",
                     taps, occ, dout, dout_vld);
        end
        din = 4'hF;
        tick();
        checks++;
        if (taps !== 8'h7F) begin
            errors++;
            $display("FAIL stall_next: taps %h want 7f", taps);
        end
        din_vld = 1'b0;
    endtask

    task automatic test_clr();
        sel = 2'd2; en = 1'b1; din_vld = 1'b1;
        din = 4'hF;
        tick();
        din = 4'hA;
        tick();
        checks++;
        if (taps !== 8'hFA || occ !== 2'd2) begin
            errors++;
            $display("FAIL clr_fill: taps %h occ %0d want fa/2", taps, occ);
        end
        clr = 1'b1; din = 4'h2;
        tick();
        checks++;
        if (occ !== 2'd0 || dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL clr_valid: occ %0d vld %b want 0/0", occ, dout_vld);
        end
        checks++;
        if (taps !== 8'hFA) begin
            errors++;
            $display("FAIL clr_data: taps %h want fa", taps);
        end
        clr = 1'b0; din_vld = 1'b0;
    endtask

    task automatic test_async_rst();
        sel = 2'd2; en = 1'b1; din_vld = 1'b1;
        din = 4'h5;
        tick();
        din = 4'h6;
        tick();
        #20 rst = 1'b1;
        #1;
        checks++;
        if (taps !== 8'h00 || occ !== 2'd0 || dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL arst_now: taps %h occ %0d vld %b want 00/0/0",
                     taps, occ, dout_vld);
        end
        din = 4'h7;
        tick();
        checks++;
        if (taps !== 8'h00 || occ !== 2'd0) begin
            errors++;
            $display("FAIL arst_hold: taps %h occ %0d want 00/0", taps, occ);
        end
        #20 rst = 1'b0;
        tick();
        checks++;
        if (taps !== 8'h07 || occ !== 2'd1) begin
            errors++;
            $display("FAIL arst_first: taps %h occ %0d want 07/1", taps, occ);
        end
        din_vld = 1'b0;
    endtask

    task automatic test_random();
        logic [16:0]  e;
        logic [127:0] et;
        int l;
        int c2;
        int c8;
        int c1;
        rst = 1'b1;
        #10 rst = 1'b0;
        h.delete();
        for (int k = 0; k < 8; k++) h.push_back(17'h0);
        for (int n = 0; n < 1000; n++) begin
            en      = ($urandom_range(3) != 0);
            clr     = ($urandom_range(15) == 0);
            din16   = 16'($urandom);
            din     = din16[3:0];
            din_vld = 1'($urandom_range(1));
            sel     = 2'($urandom_range(3));
            sel8    = 4'($urandom_range(15));
            sel1    = 1'($urandom_range(1));
            #1;
            l = (int'(sel) > 2) ? 2 : int'(sel);
            e = (l == 0) ? {din_vld, din16} : h[l-1];
            checks++;
            if (dout !== e[3:0] || dout_vld !== e[16]) begin
                errors++;
                $display("FAIL rnd_d2[%0d]: got %h/%b want %h/%b sel %0d",
                         n, dout, dout_vld, e[3:0], e[16], sel);
            end
            l = (int'(sel8) > 8) ? 8 : int'(sel8);
            e = (l == 0) ? {din_vld, din16} : h[l-1];
            checks++;
            if (dout8 !== e[15:0] || dout8_vld !== e[16]) begin
                errors++;
                $display("FAIL rnd_d8[%0d]: got %h/%b want %h/%b sel %0d",
                         n, dout8, dout8_vld, e[15:0], e[16], sel8);
            end
            e = (sel1 == 1'b0) ? {din_vld, din16} : h[0];
            checks++;
            if (dout1 !== e[0:0] || dout1_vld !== e[16]) begin
                errors++;
                $display("FAIL rnd_d1[%0d]: got %b/%b want %b/%b sel %0d",
                         n, dout1, dout1_vld, e[0], e[16], sel1);
            end
            c2 = 0; c8 = 0; c1 = 0;
            et = '0;
            for (int k = 0; k < 8; k++) begin
                if (h[k][16]) begin
                    c8++;
                    if (k < 2) c2++;
                    if (k < 1) c1++;
                end
                et[k*16 +: 16] = h[k][15:0];
            end
            checks++;
            if (int'(occ) != c2 || int'(occ8) != c8 || int'(occ1) != c1) begin
                errors++;
                $display("FAIL rnd_occ[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
                         n, occ, occ8, occ1, c2, c8, c1);
            end
            checks++;
            if (taps8 !== et || taps !== {et[19:16], et[3:0]} || taps1 !== et[0:0]) begin
                errors++;
                $display("FAIL rnd_taps[%0d]: got %h want %h", n, taps8, et);
            end
            if (clr) begin
                for (int k = 0; k < 8; k++) h[k] = h[k] & 17'h0FFFF;
            end else if (en) begin
                h.push_front({din_vld, din16});
                void'(h.pop_back());
            end
            tick();
        end
        en = 1'b0; clr = 1'b0; din_vld = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream_taps();
        run_stream(2'd0);
        run_stream(2'd1);
        run_stream(2'd2);
        run_stream(2'd3);
        test_stall();
        test_clr();
        test_async_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
